// File: rtl/msrh_lsu_pkg.sv
// Shared types and constants for the store-miss refill queue (LRQ).
// Holds the per-entry state enum, the entry record and small one-hot helpers.
package msrh_lsu_pkg;

  localparam int LRQ_SIZE   = 4;
  localparam int PADDR_W    = 56;
  localparam int LINE_W     = 512;
  localparam int LINE_B_W   = LINE_W / 8;
  localparam int LINE_OFS_W = $clog2(LINE_B_W);
  localparam int LRQ_IDX_W  = $clog2(LRQ_SIZE);

  typedef enum logic [2:0] {
    FREE,
    L2_REQ,
    L2_WAIT,
    L1D_WR,
    RESOLVE
  } lrq_state_t;

  typedef struct packed {
    lrq_state_t         state;
    logic [PADDR_W-1:0] paddr;
    logic [LINE_W-1:0]  data;
  } lrq_entry_t;

  function automatic logic [PADDR_W-1:0] line_align(input logic [PADDR_W-1:0] paddr);
    return {paddr[PADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
  endfunction

  function automatic logic [LRQ_SIZE-1:0] lowest_oh(input logic [LRQ_SIZE-1:0] vec);
    return vec & (~vec + LRQ_SIZE'(1));
  endfunction

  function automatic logic [LRQ_IDX_W-1:0] oh_to_idx(input logic [LRQ_SIZE-1:0] oh);
    logic [LRQ_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < LRQ_SIZE; i++) begin
      if (oh[i]) idx = idx | LRQ_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/msrh_lrq_stq_refill_if.sv
// Bundle of store-queue request, L2 request/response, L1D write and resolve signals.
// The refill queue sits on the slave modport; its environment uses master.
interface msrh_lrq_stq_refill_if;
  import msrh_lsu_pkg::*;

  logic                 i_lrq_load;
  logic [PADDR_W-1:0]   i_lrq_paddr;
  logic                 o_lrq_full;
  logic                 o_lrq_conflict;
  logic [LRQ_SIZE-1:0]  o_lrq_index_oh;

  logic                 o_l2_req_valid;
  logic                 i_l2_req_ready;
  logic [PADDR_W-1:0]   o_l2_req_paddr;
  logic [LRQ_IDX_W-1:0] o_l2_req_tag;

  logic                 i_l2_resp_valid;
  logic [LRQ_IDX_W-1:0] i_l2_resp_tag;
  logic [LINE_W-1:0]    i_l2_resp_data;

  logic                 o_l1d_wr_valid;
  logic [PADDR_W-1:0]   o_l1d_wr_paddr;
  logic [LINE_W-1:0]    o_l1d_wr_data;
  logic [LINE_B_W-1:0]  o_l1d_wr_be;
  logic                 i_l1d_wr_conflict;

  logic                 o_lrq_resolve_valid;
  logic [LRQ_SIZE-1:0]  o_lrq_resolve_index_oh;

  modport slave (
    input  i_lrq_load, i_lrq_paddr, i_l2_req_ready, i_l2_resp_valid, i_l2_resp_tag,
           i_l2_resp_data, i_l1d_wr_conflict,
    output o_lrq_full, o_lrq_conflict, o_lrq_index_oh, o_l2_req_valid, o_l2_req_paddr,
           o_l2_req_tag, o_l1d_wr_valid, o_l1d_wr_paddr, o_l1d_wr_data, o_l1d_wr_be,
           o_lrq_resolve_valid, o_lrq_resolve_index_oh
  );

  modport master (
    output i_lrq_load, i_lrq_paddr, i_l2_req_ready, i_l2_resp_valid, i_l2_resp_tag,
           i_l2_resp_data, i_l1d_wr_conflict,
    input  o_lrq_full, o_lrq_conflict, o_lrq_index_oh, o_l2_req_valid, o_l2_req_paddr,
           o_l2_req_tag, o_l1d_wr_valid, o_l1d_wr_paddr, o_l1d_wr_data, o_l1d_wr_be,
           o_lrq_resolve_valid, o_lrq_resolve_index_oh
  );

endinterface

// File: rtl/msrh_lrq_stq_refill_entry.sv
// One refill entry: FREE -> L2_REQ -> L2_WAIT -> L1D_WR -> RESOLVE -> FREE,
// with the line address and the refill data it carries.
module msrh_lrq_stq_refill_entry
  import msrh_lsu_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_alloc,
  input  logic [PADDR_W-1:0] i_alloc_paddr,
  input  logic               i_l2_req_fire,
  input  logic               i_l2_resp_valid,
  input  logic [LINE_W-1:0]  i_l2_resp_data,
  input  logic               i_l1d_wr_done,
  output lrq_entry_t         o_entry
);

  lrq_state_t         r_state;
  lrq_state_t         w_state_next;
  logic [PADDR_W-1:0] r_paddr;
  logic [LINE_W-1:0]  r_data;
  logic               w_resp_take;

  assign w_resp_take = (r_state == L2_WAIT) && i_l2_resp_valid;

  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      FREE:    if (i_alloc)        w_state_next = L2_REQ;
      L2_REQ:  if (i_l2_req_fire)  w_state_next = L2_WAIT;
      L2_WAIT: if (w_resp_take)    w_state_next = L1D_WR;
      L1D_WR:  if (i_l1d_wr_done)  w_state_next = RESOLVE;
      RESOLVE:                     w_state_next = FREE;
      default:                     w_state_next = FREE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: non-blocking assignments so all flops sample pre-edge values together.
    if (i_reset) begin
      r_state <= FREE;
      r_paddr <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_alloc) r_paddr <= line_align(i_alloc_paddr);
    end
  end

  // NOTE: the line buffer is not reset; it is only read after a response fills it.
  always_ff @(posedge i_clk) begin
    if (w_resp_take) r_data <= i_l2_resp_data;
  end

  assign o_entry = '{state: r_state, paddr: r_paddr, data: r_data};

endmodule

// File: rtl/msrh_lrq_stq_refill.sv
// Store-miss refill queue: match/allocate on store-queue misses, then L2 fetch,
// L1D write and resolve broadcast. Optional counters under MSRH_LRQ_PERF_CNT_EN.
module msrh_lrq_stq_refill
  import msrh_lsu_pkg::*;
(
  input logic                  i_clk,
  input logic                  i_reset,
  msrh_lrq_stq_refill_if.slave io_bus
`ifdef MSRH_LRQ_PERF_CNT_EN
  ,
  output logic [31:0]          o_perf_alloc_cnt,
  output logic [31:0]          o_perf_merge_cnt,
  output logic [31:0]          o_perf_full_cnt
`endif
);

  lrq_entry_t          w_entry [LRQ_SIZE];
  logic [LRQ_SIZE-1:0] w_match, w_free, w_l2_req, w_l1d_wr, w_resolve;
  logic [LRQ_SIZE-1:0] w_alloc_oh, w_l2_oh, w_l1d_oh;
  logic [LRQ_SIZE-1:0] r_l2_hold_oh;
  logic [PADDR_W-1:0]  w_req_line;
  logic                w_load, w_hit, w_alloc, w_full, w_l2_fire;

  assign w_req_line = line_align(io_bus.i_lrq_paddr);

  // RESOLVE entries are neither matchable nor free.
  always_comb begin
    w_match   = '0;
    w_free    = '0;
    w_l2_req  = '0;
    w_l1d_wr  = '0;
    w_resolve = '0;
    for (int i = 0; i < LRQ_SIZE; i++) begin
      w_match[i]   = (w_entry[i].state inside {L2_REQ, L2_WAIT, L1D_WR}) &&
                     (w_entry[i].paddr == w_req_line);
      w_free[i]    = (w_entry[i].state == FREE);
      w_l2_req[i]  = (w_entry[i].state == L2_REQ);
      w_l1d_wr[i]  = (w_entry[i].state == L1D_WR);
      w_resolve[i] = (w_entry[i].state == RESOLVE);
    end
  end

  assign w_load     = io_bus.i_lrq_load & ~i_reset;
  assign w_hit      = |w_match;
  assign w_alloc    = w_load & ~w_hit & (|w_free);
  assign w_full     = w_load & ~w_hit & ~(|w_free);
  assign w_alloc_oh = w_alloc ? lowest_oh(w_free) : '0;

  assign io_bus.o_lrq_conflict = w_load & w_hit;
  assign io_bus.o_lrq_full     = w_full;
  assign io_bus.o_lrq_index_oh = (w_load & w_hit) ? lowest_oh(w_match) : w_alloc_oh;

  // A stalled L2 request keeps its entry until accepted, even if a lower index arrives.
  assign w_l2_oh   = (r_l2_hold_oh != '0) ? r_l2_hold_oh : lowest_oh(w_l2_req);
  assign w_l2_fire = (|w_l2_oh) & io_bus.i_l2_req_ready;
  assign w_l1d_oh  = lowest_oh(w_l1d_wr);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_l2_hold_oh <= '0;
    else         r_l2_hold_oh <= ((|w_l2_oh) & ~io_bus.i_l2_req_ready) ? w_l2_oh : '0;
  end

  always_comb begin
    io_bus.o_l2_req_paddr = '0;
    io_bus.o_l1d_wr_paddr = '0;
    io_bus.o_l1d_wr_data  = '0;
    for (int i = 0; i < LRQ_SIZE; i++) begin
      io_bus.o_l2_req_paddr = io_bus.o_l2_req_paddr | ({PADDR_W{w_l2_oh[i]}} & w_entry[i].paddr);
      io_bus.o_l1d_wr_paddr = io_bus.o_l1d_wr_paddr | ({PADDR_W{w_l1d_oh[i]}} & w_entry[i].paddr);
      io_bus.o_l1d_wr_data  = io_bus.o_l1d_wr_data  | ({LINE_W{w_l1d_oh[i]}} & w_entry[i].data);
    end
  end

  assign io_bus.o_l2_req_valid         = |w_l2_oh;
  assign io_bus.o_l2_req_tag           = oh_to_idx(w_l2_oh);
  assign io_bus.o_l1d_wr_valid         = |w_l1d_oh;
  assign io_bus.o_l1d_wr_be            = {LINE_B_W{|w_l1d_oh}};
  assign io_bus.o_lrq_resolve_valid    = |w_resolve;
  assign io_bus.o_lrq_resolve_index_oh = w_resolve;

  for (genvar g = 0; g < LRQ_SIZE; g++) begin : g_entry
    msrh_lrq_stq_refill_entry u_entry (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_alloc         (w_alloc_oh[g]),
      .i_alloc_paddr   (io_bus.i_lrq_paddr),
      .i_l2_req_fire   (w_l2_fire & w_l2_oh[g]),
      .i_l2_resp_valid (io_bus.i_l2_resp_valid && (io_bus.i_l2_resp_tag == LRQ_IDX_W'(g))),
      .i_l2_resp_data  (io_bus.i_l2_resp_data),
      .i_l1d_wr_done   (w_l1d_oh[g] & ~io_bus.i_l1d_wr_conflict),
      .o_entry         (w_entry[g])
    );
  end

`ifdef MSRH_LRQ_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_perf_alloc_cnt <= '0;
      o_perf_merge_cnt <= '0;
      o_perf_full_cnt  <= '0;
    end else begin
      if (w_alloc && !(&o_perf_alloc_cnt))          o_perf_alloc_cnt <= o_perf_alloc_cnt + 32'd1;
      if (w_load && w_hit && !(&o_perf_merge_cnt))  o_perf_merge_cnt <= o_perf_merge_cnt + 32'd1;
      if (w_full && !(&o_perf_full_cnt))            o_perf_full_cnt  <= o_perf_full_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msrh_lrq_stq_refill.sv
// Self-checking bench for msrh_lrq_stq_refill: directed scenarios plus a randomized
// run scored against a line-level model of allocation, merge and refill completion.
module tb_msrh_lrq_stq_refill;
  import msrh_lsu_pkg::*;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  msrh_lrq_stq_refill_if bus ();

`ifdef MSRH_LRQ_PERF_CNT_EN
  logic [31:0] perf_alloc, perf_merge, perf_full;
`endif

  msrh_lrq_stq_refill dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus.slave)
`ifdef MSRH_LRQ_PERF_CNT_EN
    ,
    .o_perf_alloc_cnt (perf_alloc),
    .o_perf_merge_cnt (perf_merge),
    .o_perf_full_cnt  (perf_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.i_lrq_load        = 1'b0;
    bus.i_lrq_paddr       = '0;
    bus.i_l2_req_ready    = 1'b1;
    bus.i_l2_resp_valid   = 1'b0;
    bus.i_l2_resp_tag     = '0;
    bus.i_l2_resp_data    = '0;
    bus.i_l1d_wr_conflict = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    bus.i_lrq_load      = 1'b0;
    bus.i_l2_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [PADDR_W-1:0] pa);
    bus.i_lrq_load  = 1'b1;
    bus.i_lrq_paddr = pa;
  endtask

  task automatic respond(input logic [LRQ_IDX_W-1:0] tag, input logic [LINE_W-1:0] d);
    bus.i_l2_resp_valid = 1'b1;
    bus.i_l2_resp_tag   = tag;
    bus.i_l2_resp_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    n_tests++;
    if ({bus.o_l2_req_valid, bus.o_l1d_wr_valid, bus.o_lrq_resolve_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_valids: got %b want 000",
               {bus.o_l2_req_valid, bus.o_l1d_wr_valid, bus.o_lrq_resolve_valid});
    end
    n_tests++;
    if ({bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh, bus.o_lrq_resolve_index_oh} !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: got %b want 0",
               {bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh, bus.o_lrq_resolve_index_oh});
    end
    n_tests++;
    if ({bus.o_l2_req_paddr, bus.o_l2_req_tag, bus.o_l1d_wr_paddr} !== '0 ||
        bus.o_l1d_wr_data !== '0 || bus.o_l1d_wr_be !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got paddr %h/%h tag %h be %h want 0", bus.o_l2_req_paddr,
               bus.o_l1d_wr_paddr, bus.o_l2_req_tag, bus.o_l1d_wr_be);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc(); #1;
    n_tests++;
    if ({bus.o_l2_req_valid, bus.o_l1d_wr_valid, bus.o_lrq_resolve_valid, bus.o_lrq_index_oh} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want 0",
               {bus.o_l2_req_valid, bus.o_l1d_wr_valid, bus.o_lrq_resolve_valid, bus.o_lrq_index_oh});
    end
  endtask

  task automatic test_single_miss();
    logic [LINE_W-1:0] d = {LINE_B_W{8'hA5}};
    do_reset();
    cyc(); load(56'h0000_8000_1234); #1;
    n_tests++;
    if ({bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh} !== {2'b00, 4'b0001}) begin
      n_fail++;
      $display("FAIL single_alloc: got %b want 000001", {bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh});
    end
    cyc(); #1;
    n_tests++;
    if ({bus.o_l2_req_valid, bus.o_l2_req_paddr, bus.o_l2_req_tag} !== {1'b1, 56'h0000_8000_1200, 2'd0}) begin
      n_fail++;
      $display("FAIL single_l2_req: got v=%b pa=%h tag=%0d want v=1 pa=80001200 tag=0",
               bus.o_l2_req_valid, bus.o_l2_req_paddr, bus.o_l2_req_tag);
    end
    cyc(); respond(2'd0, d); #1;
    n_tests++;
    if (bus.o_l2_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_l2_req_drop: got %b want 0", bus.o_l2_req_valid);
    end
    cyc(); #1;
    n_tests++;
    if ({bus.o_l1d_wr_valid, bus.o_l1d_wr_paddr, bus.o_lrq_resolve_valid} !== {1'b1, 56'h0000_8000_1200, 1'b0}) begin
      n_fail++;
      $display("FAIL single_l1d_wr: got v=%b pa=%h rv=%b want v=1 pa=80001200 rv=0",
               bus.o_l1d_wr_valid, bus.o_l1d_wr_paddr, bus.o_lrq_resolve_valid);
    end
    n_tests++;
    if (bus.o_l1d_wr_data !== d || bus.o_l1d_wr_be !== {LINE_B_W{1'b1}}) begin
      n_fail++;
      $display("FAIL single_l1d_data: got data %h be %h want data %h be all ones",
               bus.o_l1d_wr_data, bus.o_l1d_wr_be, d);
    end
    cyc(); #1;
    n_tests++;
    if ({bus.o_lrq_resolve_valid, bus.o_lrq_resolve_index_oh, bus.o_l1d_wr_valid} !== {1'b1, 4'b0001, 1'b0}) begin
      n_fail++;
      $display("FAIL single_resolve: got %b want 100010",
               {bus.o_lrq_resolve_valid, bus.o_lrq_resolve_index_oh, bus.o_l1d_wr_valid});
    end
    cyc(); #1;
    n_tests++;
    if ({bus.o_lrq_resolve_valid, bus.o_lrq_resolve_index_oh} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_resolve_once: got %b want 00000", {bus.o_lrq_resolve_valid, bus.o_lrq_resolve_index_oh});
    end
  endtask

  task automatic test_merge();
    do_reset();
    cyc(); load(56'h0000_8000_1234); #1;
    cyc(); load(56'h0000_8000_123F); #1;
    n_tests++;
    if ({bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh} !== {2'b01, 4'b0001}) begin
      n_fail++;
      $display("FAIL merge_l2req: got %b want 010001", {bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh});
    end
    cyc(); load(56'h0000_8000_1210); #1;
    n_tests++;
    if ({bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh} !== {2'b01, 4'b0001}) begin
      n_fail++;
      $display("FAIL merge_l2wait: got %b want 010001", {bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh});
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      n_tests++;
      if (bus.o_l2_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL merge_no_second_req: cycle %0d got %b want 0", i, bus.o_l2_req_valid);
      end
    end
  endtask

  task automatic test_full();
    logic [PADDR_W-1:0] base = 56'h0000_1000_0000;
    logic [5:0] got;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(); load(base + PADDR_W'(k * 64 + 5)); #1;
      got = {bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh};
      n_tests++;
      if (k < 4 && got !== {2'b00, 4'(1 << k)}) begin
        n_fail++;
        $display("FAIL full_alloc%0d: got %b want 00%b", k, got, 4'(1 << k));
      end else if (k == 4 && got !== 6'b100000) begin
        n_fail++;
        $display("FAIL full_reject: got %b want 100000", got);
      end
    end
    cyc(); respond(2'd2, {16{32'h2222_0000}}); #1;
    cyc(); #1;
    n_tests++;
    if ({bus.o_l1d_wr_valid, bus.o_l1d_wr_paddr} !== {1'b1, base + PADDR_W'(128)}) begin
      n_fail++;
      $display("FAIL full_wr2: got v=%b pa=%h want v=1 pa=%h", bus.o_l1d_wr_valid, bus.o_l1d_wr_paddr, base + PADDR_W'(128));
    end
    cyc(); load(base + PADDR_W'(4 * 64)); #1;
    n_tests++;
    if ({bus.o_lrq_resolve_index_oh, bus.o_lrq_full, bus.o_lrq_index_oh} !== {4'b0100, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL full_during_resolve: got %b want 010010000",
               {bus.o_lrq_resolve_index_oh, bus.o_lrq_full, bus.o_lrq_index_oh});
    end
    cyc(); load(base + PADDR_W'(4 * 64)); #1;
    n_tests++;
    if ({bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh} !== {2'b00, 4'b0100}) begin
      n_fail++;
      $display("FAIL full_realloc: got %b want 000100", {bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh});
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.i_l2_req_ready = 1'b0;
    cyc(); load(56'h00AB_CDEF_0077); #1;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      n_tests++;
      if ({bus.o_l2_req_valid, bus.o_l2_req_paddr, bus.o_l2_req_tag} !== {1'b1, 56'h00AB_CDEF_0040, 2'd0}) begin
        n_fail++;
        $display("FAIL bp_l2_hold%0d: got v=%b pa=%h want v=1 pa=00abcdef0040", i,
                 bus.o_l2_req_valid, bus.o_l2_req_paddr);
      end
    end
    cyc(); bus.i_l2_req_ready = 1'b1; #1;
    cyc(); respond(2'd0, {16{32'hDEAD_BEEF}}); #1;
    n_tests++;
    if (bus.o_l2_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_l2_accept: got %b want 0", bus.o_l2_req_valid);
    end
    bus.i_l1d_wr_conflict = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) bus.i_l1d_wr_conflict = 1'b0;
      #1;
      n_tests++;
      if ({bus.o_l1d_wr_valid, bus.o_l1d_wr_paddr, bus.o_lrq_resolve_valid} !== {1'b1, 56'h00AB_CDEF_0040, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_wr_retry%0d: got v=%b pa=%h rv=%b want v=1 pa=00abcdef0040 rv=0", i,
                 bus.o_l1d_wr_valid, bus.o_l1d_wr_paddr, bus.o_lrq_resolve_valid);
      end
    end
    cyc(); #1;
    n_tests++;
    if ({bus.o_lrq_resolve_valid, bus.o_lrq_resolve_index_oh, bus.o_l1d_wr_valid} !== {1'b1, 4'b0001, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_resolve: got %b want 100010",
               {bus.o_lrq_resolve_valid, bus.o_lrq_resolve_index_oh, bus.o_l1d_wr_valid});
    end
  endtask

  task automatic test_out_of_order();
    logic [PADDR_W-1:0] pa_a = 56'h0000_0000_4000;
    logic [PADDR_W-1:0] pa_b = 56'h0012_3456_7880;
    logic [LINE_W-1:0]  d_a  = {16{32'hAAAA_0001}};
    logic [LINE_W-1:0]  d_b  = {16{32'hBBBB_0002}};
    do_reset();
    cyc(); load(pa_a); #1;
    cyc(); load(pa_b + PADDR_W'(9)); #1;
    cyc(); #1;
    cyc(); respond(2'd1, d_b); #1;
    cyc(); respond(2'd0, d_a); #1;
    n_tests++;
    if ({bus.o_l1d_wr_valid, bus.o_l1d_wr_paddr} !== {1'b1, pa_b} || bus.o_l1d_wr_data !== d_b) begin
      n_fail++;
      $display("FAIL ooo_wr_b: got v=%b pa=%h want v=1 pa=%h", bus.o_l1d_wr_valid, bus.o_l1d_wr_paddr, pa_b);
    end
    cyc(); load(pa_b); #1;
    n_tests++;
    if ({bus.o_lrq_resolve_index_oh, bus.o_l1d_wr_paddr} !== {4'b0010, pa_a} || bus.o_l1d_wr_data !== d_a) begin
      n_fail++;
      $display("FAIL ooo_resolve_b: got oh=%b pa=%h want oh=0010 pa=%h",
               bus.o_lrq_resolve_index_oh, bus.o_l1d_wr_paddr, pa_a);
    end
    n_tests++;
    if ({bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh} !== {2'b00, 4'b0100}) begin
      n_fail++;
      $display("FAIL ooo_resolve_nomatch: got %b want 000100",
               {bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh});
    end
    cyc(); respond(2'd3, {16{32'h5555_5555}}); #1;
    n_tests++;
    if ({bus.o_lrq_resolve_index_oh, bus.o_l2_req_valid, bus.o_l2_req_tag, bus.o_l2_req_paddr} !==
        {4'b0001, 1'b1, 2'd2, pa_b}) begin
      n_fail++;
      $display("FAIL ooo_resolve_a: got oh=%b l2v=%b tag=%0d pa=%h want oh=0001 l2v=1 tag=2 pa=%h",
               bus.o_lrq_resolve_index_oh, bus.o_l2_req_valid, bus.o_l2_req_tag, bus.o_l2_req_paddr, pa_b);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      n_tests++;
      if ({bus.o_l1d_wr_valid, bus.o_lrq_resolve_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL ooo_stray_dropped%0d: got %b want 00", i, {bus.o_l1d_wr_valid, bus.o_lrq_resolve_valid});
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    cyc(); load(56'h0000_0F00_0000); #1;
    cyc(); load(56'h0000_0F00_0040); #1;
    cyc(); #1;
    cyc(); rst = 1'b1; #1;
    n_tests++;
    if ({bus.o_l2_req_valid, bus.o_l1d_wr_valid, bus.o_lrq_resolve_valid,
         bus.o_l2_req_paddr, bus.o_l1d_wr_paddr, bus.o_lrq_resolve_index_oh} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got l2v=%b wv=%b rv=%b pa=%h want all 0",
               bus.o_l2_req_valid, bus.o_l1d_wr_valid, bus.o_lrq_resolve_valid, bus.o_l2_req_paddr);
    end
    cyc(); rst = 1'b0; #1;
    cyc(); respond(2'd0, {16{32'h0BAD_F00D}}); #1;
    cyc(); load(56'h0000_0F00_0000); #1;
    n_tests++;
    if ({bus.o_l1d_wr_valid, bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh} !== {3'b000, 4'b0001}) begin
      n_fail++;
      $display("FAIL midreset_late_resp: got %b want 0000001",
               {bus.o_l1d_wr_valid, bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh});
    end
  endtask

  // Line-level model: the queue of allocated lines is indexed by entry number, since
  // entries are handed out lowest-first from an empty queue and nothing retires while loading.
  task automatic test_random();
    for (int round = 0; round < 8; round++) begin
      logic [PADDR_W-1:0] lines[$];
      logic [PADDR_W-1:0] sched[$];
      logic [PADDR_W-1:0] model_line[$];
      logic [LINE_W-1:0]  rdata[LRQ_SIZE];
      bit                 resp_sent[LRQ_SIZE];
      bit                 wr_done[LRQ_SIZE];
      bit                 resolved[LRQ_SIZE];
      int                 pend[$];
      int                 n_lines, next_req, n_res, cycles;
      logic [63:0]        raw;
      n_lines  = int'($urandom_range(1, 6));
      next_req = 0;
      n_res    = 0;
      cycles   = 0;
      for (int t = 0; t < LRQ_SIZE; t++) begin
        resp_sent[t] = 0; wr_done[t] = 0; resolved[t] = 0; rdata[t] = '0;
      end
      while (lines.size() < n_lines) begin
        bit dup = 0;
        raw = {$urandom(), $urandom()};
        foreach (lines[k]) if (lines[k] == line_align(raw[PADDR_W-1:0])) dup = 1;
        if (!dup) lines.push_back(line_align(raw[PADDR_W-1:0]));
      end
      for (int i = 0; i < n_lines; i++) begin
        sched.push_back(lines[i] | PADDR_W'($urandom_range(0, LINE_B_W - 1)));
        if ($urandom_range(0, 1) == 1)
          sched.push_back(lines[$urandom_range(0, i)] | PADDR_W'($urandom_range(0, LINE_B_W - 1)));
      end
      do_reset();
      while (cycles < 500) begin
        bit issued = 0;
        logic [PADDR_W-1:0] ld = '0;
        cyc();
        bus.i_l2_req_ready    = ($urandom_range(0, 3) != 0);
        bus.i_l1d_wr_conflict = ($urandom_range(0, 3) == 0);
        if (sched.size() > 0) begin
          if ($urandom_range(0, 2) != 0) begin
            ld = sched.pop_front();
            load(ld);
            issued = 1;
          end
        end else if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
          int k = int'($urandom_range(0, pend.size() - 1));
          int tag = pend[k];
          logic [LINE_W-1:0] d;
          for (int w = 0; w < LINE_W / 32; w++) d[w*32 +: 32] = $urandom();
          pend.delete(k);
          respond(LRQ_IDX_W'(tag), d);
          rdata[tag] = d;
          resp_sent[tag] = 1;
        end
        #1;
        if (issued) begin
          int j = -1;
          logic [5:0] exp_resp;
          foreach (model_line[k]) if (model_line[k] == line_align(ld)) j = k;
          if (j >= 0) exp_resp = {2'b01, 4'(1 << j)};
          else if (model_line.size() < LRQ_SIZE) begin
            exp_resp = {2'b00, 4'(1 << model_line.size())};
            model_line.push_back(line_align(ld));
          end else exp_resp = 6'b100000;
          n_tests++;
          if ({bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh} !== exp_resp) begin
            n_fail++;
            $display("FAIL rnd_resp r%0d pa=%h: got %b want %b", round, ld,
                     {bus.o_lrq_full, bus.o_lrq_conflict, bus.o_lrq_index_oh}, exp_resp);
          end
        end
        if (bus.o_l2_req_valid && bus.i_l2_req_ready) begin
          int tag = int'(bus.o_l2_req_tag);
          n_tests++;
          if (tag != next_req || tag >= model_line.size() || bus.o_l2_req_paddr !== model_line[tag]) begin
            n_fail++;
            $display("FAIL rnd_l2_req r%0d: got tag=%0d pa=%h want tag=%0d of %0d allocated",
                     round, tag, bus.o_l2_req_paddr, next_req, model_line.size());
          end
          next_req++;
          pend.push_back(tag);
        end
        if (bus.o_l1d_wr_valid && !bus.i_l1d_wr_conflict) begin
          int j = -1;
          foreach (model_line[k]) if (model_line[k] == bus.o_l1d_wr_paddr) j = k;
          n_tests++;
          if (j < 0 || !resp_sent[j] || wr_done[j] || bus.o_l1d_wr_data !== rdata[j] ||
              bus.o_l1d_wr_be !== {LINE_B_W{1'b1}}) begin
            n_fail++;
            $display("FAIL rnd_l1d_wr r%0d: got pa=%h entry=%0d be=%h, want an answered line with its data",
                     round, bus.o_l1d_wr_paddr, j, bus.o_l1d_wr_be);
          end
          if (j >= 0) wr_done[j] = 1;
        end
        if (bus.o_lrq_resolve_valid || bus.o_lrq_resolve_index_oh != '0) begin
          for (int b = 0; b < LRQ_SIZE; b++) begin
            if (bus.o_lrq_resolve_index_oh[b]) begin
              n_tests++;
              if (!bus.o_lrq_resolve_valid || !wr_done[b] || resolved[b]) begin
                n_fail++;
                $display("FAIL rnd_resolve r%0d: entry %0d valid=%b written=%0d already=%0d",
                         round, b, bus.o_lrq_resolve_valid, wr_done[b], resolved[b]);
              end
              resolved[b] = 1;
              n_res++;
            end
          end
        end
        if (sched.size() == 0 && n_res >= model_line.size()) break;
        cycles++;
      end
      n_tests++;
      if (n_res != model_line.size()) begin
        n_fail++;
        $display("FAIL rnd_complete r%0d: got %0d resolves want %0d", round, n_res, model_line.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_merge();
    test_full();
    test_backpressure();
    test_out_of_order();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/msrh_lrq_stq_refill.md
Name: msrh_lrq_stq_refill

Overview:
Responder side of the store-miss refill path. It accepts line-miss requests from the store queue after a committed store misses in L1D. Each request allocates or merges into a refill entry, which fetches the line from L2, writes it into L1D, and then broadcasts a resolve one-hot so waiting store entries retry. Sits in the L1D subsystem between the store queue, the L2 request/response port and the L1D write port.

Parameters:
LRQ_SIZE, 4, number of refill entries (power of 2, >=2)
PADDR_W, 56, physical address width
LINE_W, 512, cache line / L2 data width in bits
LINE_B_W, LINE_W/8, line byte count (derived)

Ports:
i_clk  input  1  clock; all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_lrq_load  input  1  store-miss refill request valid
i_lrq_paddr  input  PADDR_W  miss address (low $clog2(LINE_B_W) bits ignored)
o_lrq_full  output  1  same-cycle response: rejected, no free entry and no match
o_lrq_conflict  output  1  same-cycle response: merged into existing entry
o_lrq_index_oh  output  LRQ_SIZE  same-cycle response: allocated or matched entry
o_l2_req_valid  output  1  L2 line read request
i_l2_req_ready  input  1  L2 accepts request
o_l2_req_paddr  output  PADDR_W  line-aligned address
o_l2_req_tag  output  $clog2(LRQ_SIZE)  entry index
i_l2_resp_valid  input  1  L2 refill data valid (no backpressure)
i_l2_resp_tag  input  $clog2(LRQ_SIZE)  entry index
i_l2_resp_data  input  LINE_W  line data
o_l1d_wr_valid  output  1  L1D line write request
o_l1d_wr_paddr  output  PADDR_W  line-aligned address
o_l1d_wr_data  output  LINE_W  line data
o_l1d_wr_be  output  LINE_B_W  byte enable (all ones)
i_l1d_wr_conflict  input  1  same-cycle write reject; retry
o_lrq_resolve_valid  output  1  one or more entries resolved this cycle
o_lrq_resolve_index_oh  output  LRQ_SIZE  resolved entries

Behaviour:
- Entry FSM: FREE -> L2_REQ -> L2_WAIT -> L1D_WR -> RESOLVE -> FREE.
- Reset:
  - All entries go to FREE.
  - Every valid output is 0.
  - o_lrq_index_oh and all address/data outputs are 0.
- Request response (combinational):
  - Match: compare line address against entries in L2_REQ, L2_WAIT or L1D_WR. On a hit: o_lrq_conflict=1, o_lrq_index_oh=matching entry, no allocation.
  - Allocate: else if a FREE entry exists, take the lowest-index FREE entry and return its one-hot with conflict=0 and full=0. The entry enters L2_REQ next edge with the line-aligned paddr latched.
  - Full: else o_lrq_full=1 and index_oh=0.
  - Responses are valid only while i_lrq_load=1 and are 0 otherwise.
- RESOLVE entries are never matched and are not free. A load to that line in the same cycle allocates a new entry; the duplicate refill is harmless.
- An entry freed on an edge becomes allocatable in the following cycle, not the same cycle.
- L2 request:
  - Lowest-index L2_REQ entry drives o_l2_req_*.
  - On valid&ready the entry moves to L2_WAIT.
  - Valid holds stable until ready.
- L2 response: the entry at i_l2_resp_tag in L2_WAIT latches data and moves to L1D_WR. A response to an entry in any other state is dropped.
- L1D write:
  - Lowest-index L1D_WR entry drives o_l1d_wr_*.
  - If i_l1d_wr_conflict=0 the entry moves to RESOLVE next edge. Otherwise it stays and re-presents next cycle.
- Resolve:
  - Each RESOLVE entry asserts its bit in o_lrq_resolve_index_oh for exactly one cycle, then goes to FREE.
  - resolve_valid is the OR of those bits.
- Pipeline flush does not affect entries; committed stores always complete.
- Latency, uncontended, L2 ready immediately, L2 latency N: load@T, l2_req@T+1, resp@T+2+N, l1d_wr@T+3+N, resolve@T+4+N.

Optional Feature:
MSRH_LRQ_PERF_CNT_EN
- Defined: adds ports o_perf_alloc_cnt, o_perf_merge_cnt and o_perf_full_cnt, each a 32-bit output, saturating at all ones, reset to 0. They increment on allocate, merge and full respectively.
- Undefined: the ports and counters do not exist.

Decomposition:
- msrh_lsu_pkg holds:
  - lrq_state_t enum (FREE, L2_REQ, L2_WAIT, L1D_WR, RESOLVE)
  - lrq_entry_t struct (state, paddr, data)
  - LRQ_SIZE constant
- Sub-module msrh_lrq_stq_refill_entry: per-entry FSM plus data register. The top holds match/allocate logic and the three lowest-index arbiters.

Test Plan:
- Single miss, paddr=0x8000_1234:
  - index_oh=0001 with conflict/full=0.
  - l2_req_paddr=0x8000_1200 next cycle.
  - resp tag 0 with data 0xA5.. -> l1d_wr with be all ones.
  - resolve_index_oh=0001 one cycle later.
- Merge: second load 0x8000_1210 while entry0 is in L2_WAIT -> conflict=1, index_oh=0001, no second l2_req.
- Full: four distinct lines fill entries 0-3; fifth load -> full=1, index_oh=0. After entry2 resolves, a load two cycles later gets index_oh=0100.
- Backpressure: l2_req_ready=0 for 5 cycles -> valid and paddr held. l1d_wr_conflict=1 for 3 cycles -> write re-presented, resolve delayed 3 cycles.
- Out-of-order responses: tags 1 then 0 -> entry1 resolves first. A stray response with tag 3 while entry3 is FREE is dropped.
- Reset asserted with entries in L2_WAIT -> all outputs 0 immediately. A late response after deassertion is ignored, and the next load gets index_oh=0001.
